dmi_link_buffer: RTL

Synthesizable Debug Module Interface (DMI) buffer between the debug transport (the DPI-driven DTM in simulation) and the debug module's DMI port. It queues transport requests, enforces one outstanding DMI transaction, returns responses through a response queue, and converts a hung transaction into a synthetic failure response after a programmable timeout so the transport never deadlocks.

---
 rtl/dmi_link_buffer.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmi_link_buffer.sv
// dmi_link_buffer
//   Sits between the debug transport (DTM) and the debug module's DMI port.
//   Transport requests are queued in a request FIFO and issued to the debug
//   module one at a time. Responses return through a first-word fall-through
//   response FIFO. If the debug module never answers, a synthetic "failed"
//   response is generated after TIMEOUT cycles so the transport cannot hang.
//
// Parameters
//   DEPTH    entries in each FIFO (power of 2, >= 2)
//   TIMEOUT  WAIT-state cycles before a synthetic failure (0 disables)
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   up_req_*            request channel from the transport (valid/ready)
//   up_resp_*           response channel to the transport (valid/ready)
//   dmi_req_*           request channel to the debug module (registered)
//   dmi_resp_*          response channel from the debug module
//   timeout_count       saturating count of synthetic failure responses
//   busy                FSM not idle or either FIFO holds data
module dmi_link_buffer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_req_valid,
  output logic        up_req_ready,
  input  logic [6:0]  up_req_addr,
  input  logic [1:0]  up_req_op,
  input  logic [31:0] up_req_data,
  output logic        up_resp_valid,
  input  logic        up_resp_ready,
  output logic [1:0]  up_resp_resp,
  output logic [31:0] up_resp_data,
  output logic        dmi_req_valid,
  input  logic        dmi_req_ready,
  output logic [6:0]  dmi_req_addr,
  output logic [1:0]  dmi_req_op,
  output logic [31:0] dmi_req_data,
  input  logic        dmi_resp_valid,
  output logic        dmi_resp_ready,
  input  logic [1:0]  dmi_resp_resp,
  input  logic [31:0] dmi_resp_data,
  output logic [15:0] timeout_count,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  // ---------------------------------------------------------------------
  // Request FIFO: {addr, op, data}
  // ---------------------------------------------------------------------
  logic [40:0]   req_mem [DEPTH];
  logic [AW-1:0] req_wr_q, req_rd_q;
  logic [CW-1:0] req_cnt_q;
  logic          req_push, req_pop, req_empty, req_full;
  logic [40:0]   req_head;

  assign req_full     = (req_cnt_q == CW'(DEPTH));
  assign req_empty    = (req_cnt_q == '0);
  assign up_req_ready = !req_full;
  assign req_push     = up_req_valid && !req_full;
  assign req_head     = req_mem[req_rd_q];

  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr_q] <= {up_req_addr, up_req_op, up_req_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_wr_q  <= '0;
      req_rd_q  <= '0;
      req_cnt_q <= '0;
    end else begin
      if (req_push) req_wr_q <= req_wr_q + AW'(1);
      if (req_pop)  req_rd_q <= req_rd_q + AW'(1);
      case ({req_push, req_pop})
        2'b10:   req_cnt_q <= req_cnt_q + CW'(1);
        2'b01:   req_cnt_q <= req_cnt_q - CW'(1);
        default: req_cnt_q <= req_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Response FIFO (first-word fall-through): {resp, data}
  // ---------------------------------------------------------------------
  logic [33:0]   resp_mem [DEPTH];
  logic [AW-1:0] resp_wr_q, resp_rd_q;
  logic [CW-1:0] resp_cnt_q;
  logic          resp_push, resp_pop;
  logic [33:0]   resp_push_data;

  assign up_resp_valid = (resp_cnt_q != '0);
  assign {up_resp_resp, up_resp_data} = resp_mem[resp_rd_q];
  assign resp_pop      = up_resp_valid && up_resp_ready;

  always_ff @(posedge clk) begin
    if (resp_push) resp_mem[resp_wr_q] <= resp_push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resp_wr_q  <= '0;
      resp_rd_q  <= '0;
      resp_cnt_q <= '0;
    end else begin
      if (resp_push) resp_wr_q <= resp_wr_q + AW'(1);
      if (resp_pop)  resp_rd_q <= resp_rd_q + AW'(1);
      case ({resp_push, resp_pop})
        2'b10:   resp_cnt_q <= resp_cnt_q + CW'(1);
        2'b01:   resp_cnt_q <= resp_cnt_q - CW'(1);
        default: resp_cnt_q <= resp_cnt_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Transaction FSM
  // ---------------------------------------------------------------------
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   tcnt_q, tcnt_d;
  logic          timer_hit;

  // With TIMEOUT == 0 the timer never expires.
  assign timer_hit = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    tcnt_d         = tcnt_q;
    req_pop        = 1'b0;
    resp_push      = 1'b0;
    resp_push_data = '0;
    case (state_q)
      S_IDLE: begin
        // Issuing only when the response FIFO has room guarantees the
        // eventual response push (real or synthetic) always fits.
        if (!req_empty && (resp_cnt_q < CW'(DEPTH))) begin
          req_pop = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dmi_req_ready) begin
          timer_d = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A real response takes priority over a coincident timer expiry.
        if (dmi_resp_valid) begin
          resp_push      = 1'b1;
          resp_push_data = {dmi_resp_resp, dmi_resp_data};
          state_d        = S_IDLE;
        end else if (timer_hit) begin
          resp_push      = 1'b1;
          resp_push_data = {2'd2, 32'h0};
          if (tcnt_q != 16'hFFFF) tcnt_d = tcnt_q + 16'd1;
          timer_d        = '0;
          state_d        = S_DRAIN;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_DRAIN: begin
        // Swallow the late response of the abandoned transaction, or give
        // up on it after another TIMEOUT cycles.
        if (dmi_resp_valid || timer_hit) begin
          state_d = S_IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic        dmi_req_valid_q;
  logic [6:0]  dmi_req_addr_q;
  logic [1:0]  dmi_req_op_q;
  logic [31:0] dmi_req_data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      timer_q         <= '0;
      tcnt_q          <= '0;
      dmi_req_valid_q <= 1'b0;
      dmi_req_addr_q  <= '0;
      dmi_req_op_q    <= '0;
      dmi_req_data_q  <= '0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      tcnt_q          <= tcnt_d;
      dmi_req_valid_q <= (state_d == S_REQ);
      if (req_pop) begin
        {dmi_req_addr_q, dmi_req_op_q, dmi_req_data_q} <= req_head;
      end
    end
  end

  assign dmi_req_valid  = dmi_req_valid_q;
  assign dmi_req_addr   = dmi_req_addr_q;
  assign dmi_req_op     = dmi_req_op_q;
  assign dmi_req_data   = dmi_req_data_q;
  assign dmi_resp_ready = (state_q == S_WAIT) || (state_q == S_DRAIN);
  assign timeout_count  = tcnt_q;
  assign busy           = (state_q != S_IDLE) || !req_empty || up_resp_valid;

endmodule
